// File: rtl/dual_pwm_dac_if.sv
// Bundle of the threshold-code inputs and PWM outputs of dual_pwm_dac.
// The master side (AFE control logic) supplies the duty codes and watches
// the pulse trains. The slave side is the PWM generator itself.
interface dual_pwm_dac_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] VIH;
  logic [WIDTH-1:0] VIL;
  logic             VIH_PWM;
  logic             VIL_PWM;
  logic             pwm_sync;

  modport master (
    output VIH,
    output VIL,
    input  VIH_PWM,
    input  VIL_PWM,
    input  pwm_sync
  );

  modport slave (
    input  VIH,
    input  VIL,
    output VIH_PWM,
    output VIL_PWM,
    output pwm_sync
  );
endinterface

// File: rtl/dual_pwm_dac.sv
// dual_pwm_dac: two-channel PWM generator for the AFE comparator thresholds.
// Each WIDTH-bit code becomes a pulse train with code/2^WIDTH duty. An
// external RC filter turns it into the VIH / VIL DC levels.
//
// New codes are captured into shadow registers only at a channel's own
// period boundary, so a duty change can never produce a runt pulse.
//
// Optional build macro DUAL_PWM_PHASE_OFFSET_EN: shifts the VIL channel by
// half a period. Its switching edges are then staggered against VIH. The
// VIH channel and pwm_sync are unaffected. When undefined, both channels
// share the same phase.
module dual_pwm_dac #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  dual_pwm_dac_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] HALF_PHASE = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef DUAL_PWM_PHASE_OFFSET_EN
  localparam logic [WIDTH-1:0] VIL_PHASE = HALF_PHASE;
`else
  localparam logic [WIDTH-1:0] VIL_PHASE = '0;
`endif

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_l;
  logic [WIDTH-1:0] vih_sh;
  logic [WIDTH-1:0] vil_sh;
  logic             vih_wrap;
  logic             vil_wrap;
  logic             vih_pwm_q;
  logic             vil_pwm_q;
  logic             sync_q;

  // The VIL channel sees its own view of the period counter. That view is
  // either identical to cnt or rotated by half a period. Each channel's
  // boundary is the last count of its own view.
  assign cnt_l    = cnt ^ VIL_PHASE;
  assign vih_wrap = (cnt == CNT_MAX);
  assign vil_wrap = (cnt_l == CNT_MAX);

  // The free-running period counter restarts from zero on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The VIH shadow code takes a new value only on reset or at the VIH period wrap.
  always_ff @(posedge clk) begin
    if (rst || vih_wrap) begin
      vih_sh <= bus.VIH;
    end
  end

  // The VIL shadow code takes a new value only on reset or at the VIL period wrap.
  always_ff @(posedge clk) begin
    if (rst || vil_wrap) begin
      vil_sh <= bus.VIL;
    end
  end

  // Registered compares: high while the count is below the code, giving one run per period.
  always_ff @(posedge clk) begin
    if (rst) begin
      vih_pwm_q <= 1'b0;
      vil_pwm_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      vih_pwm_q <= (cnt < vih_sh);
      vil_pwm_q <= (cnt_l < vil_sh);
      sync_q    <= (cnt == '0);
    end
  end

  assign bus.VIH_PWM  = vih_pwm_q;
  assign bus.VIL_PWM  = vil_pwm_q;
  assign bus.pwm_sync = sync_q;

endmodule

// File: tb/tb_dual_pwm_dac.sv
// Self-checking bench for dual_pwm_dac with WIDTH = 8.
// A period-level reference model tracks which code governs each channel's
// current period. It also tracks the position within that period.
module tb_dual_pwm_dac;

  localparam int PERIOD = 256;
`ifdef DUAL_PWM_PHASE_OFFSET_EN
  localparam int VIL_OFFSET = 128;
`else
  localparam int VIL_OFFSET = 0;
`endif

  logic clk;
  logic rst;

  dual_pwm_dac_if #(.WIDTH(8)) bus ();

  dual_pwm_dac #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total;
  int bad;

  // Reference model state
  int       k;
  int       code_h;
  int       code_l;
  logic     exp_h;
  logic     exp_l;
  logic     exp_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. Outputs are sampled 1 time unit after the edge.
  // The model applies the rules per period:
  // - An output is high while the channel's period position is below the
  //   code governing that period.
  // - The code for a period is the input present at the last cycle of the
  //   previous period, or at the reset edge.
  task automatic tick();
    int  in_h;
    int  in_l;
    bit  in_rst;
    int  pos;
    int  lpos;
    in_h   = int'(bus.VIH);
    in_l   = int'(bus.VIL);
    in_rst = rst;
    @(posedge clk);
    #1;
    if (in_rst) begin
      k      = 0;
      code_h = in_h;
      code_l = in_l;
      exp_h  = 1'b0;
      exp_l  = 1'b0;
      exp_s  = 1'b0;
    end else begin
      k     = k + 1;
      pos   = (k - 1) % PERIOD;
      lpos  = (pos + VIL_OFFSET) % PERIOD;
      exp_h = (pos < code_h);
      exp_l = (lpos < code_l);
      exp_s = (pos == 0);
      if (pos == PERIOD - 1) code_h = in_h;
      if (lpos == PERIOD - 1) code_l = in_l;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.VIH = 8'hAA;
    bus.VIL = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.VIH_PWM !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_vih cyc=%0d got=%b want=0", i, bus.VIH_PWM);
      end
      total++;
      if (bus.VIL_PWM !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_vil cyc=%0d got=%b want=0", i, bus.VIL_PWM);
      end
      total++;
      if (bus.pwm_sync !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_sync cyc=%0d got=%b want=0", i, bus.pwm_sync);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_duty_window();
    int   hi_h, hi_l, rise_h, rise_l;
    logic prev_h, prev_l;
    hi_h = 0; hi_l = 0; rise_h = 0; rise_l = 0;
    prev_h = bus.VIH_PWM;
    prev_l = bus.VIL_PWM;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (i == 0) begin
        total++;
        if (bus.pwm_sync !== 1'b1 || bus.VIH_PWM !== 1'b1) begin
          bad++;
          $display("[TB] FAIL duty_first sync=%b vih=%b want 1/1", bus.pwm_sync, bus.VIH_PWM);
        end
      end
      total++;
      if ({bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync} !== {exp_h, exp_l, exp_s}) begin
        bad++;
        $display("[TB] FAIL duty_model k=%0d got=%b%b%b want=%b%b%b", k,
                 bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync, exp_h, exp_l, exp_s);
      end
      if (bus.VIH_PWM === 1'b1) hi_h++;
      if (bus.VIL_PWM === 1'b1) hi_l++;
      if (prev_h === 1'b0 && bus.VIH_PWM === 1'b1) rise_h++;
      if (prev_l === 1'b0 && bus.VIL_PWM === 1'b1) rise_l++;
      prev_h = bus.VIH_PWM;
      prev_l = bus.VIL_PWM;
    end
    total++;
    if (hi_h != 170) begin
      bad++;
      $display("[TB] FAIL duty_vih_count got=%0d want=170", hi_h);
    end
    total++;
    if (hi_l != 85) begin
      bad++;
      $display("[TB] FAIL duty_vil_count got=%0d want=85", hi_l);
    end
    total++;
    if (rise_h != 1 || rise_l != 1) begin
      bad++;
      $display("[TB] FAIL duty_contiguous rises vih=%0d vil=%0d want 1/1", rise_h, rise_l);
    end
  endtask

  task automatic test_extremes();
    int hi_h, hi_l, lo_l;
    hi_h = 0; hi_l = 0; lo_l = 0;
    bus.VIH = 8'h00;
    bus.VIL = 8'hFF;
    for (int i = 0; i < 300; i++) tick();
    for (int i = 0; i < PERIOD && (k % PERIOD) != 0; i++) tick();
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      total++;
      if ({bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync} !== {exp_h, exp_l, exp_s}) begin
        bad++;
        $display("[TB] FAIL extreme_model k=%0d got=%b%b%b want=%b%b%b", k,
                 bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync, exp_h, exp_l, exp_s);
      end
      if (bus.VIH_PWM === 1'b1) hi_h++;
      if (bus.VIL_PWM === 1'b1) hi_l++;
      if (bus.VIL_PWM === 1'b0) lo_l++;
    end
    total++;
    if (hi_h != 0) begin
      bad++;
      $display("[TB] FAIL extreme_vih_zero got=%0d want=0", hi_h);
    end
    total++;
    if (hi_l != 255 || lo_l != 1) begin
      bad++;
      $display("[TB] FAIL extreme_vil_ff high=%0d low=%0d want 255/1", hi_l, lo_l);
    end
  endtask

  task automatic test_midperiod_change();
    int   hi_a, hi_b, rises;
    logic prev;
    hi_a = 0; hi_b = 0; rises = 0;
    bus.VIH = 8'h40;
    tick();
    for (int i = 0; i < PERIOD && (k % PERIOD) != 0; i++) tick();
    prev = bus.VIH_PWM;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (i == 100) bus.VIH = 8'hC0;
      tick();
      total++;
      if (bus.VIH_PWM !== exp_h) begin
        bad++;
        $display("[TB] FAIL change_model k=%0d got=%b want=%b", k, bus.VIH_PWM, exp_h);
      end
      if (bus.VIH_PWM === 1'b1) begin
        if (i < PERIOD) hi_a++;
        else hi_b++;
      end
      if (prev === 1'b0 && bus.VIH_PWM === 1'b1) rises++;
      prev = bus.VIH_PWM;
    end
    total++;
    if (hi_a != 64) begin
      bad++;
      $display("[TB] FAIL change_old_period got=%0d want=64", hi_a);
    end
    total++;
    if (hi_b != 192) begin
      bad++;
      $display("[TB] FAIL change_new_period got=%0d want=192", hi_b);
    end
    total++;
    if (rises != 2) begin
      bad++;
      $display("[TB] FAIL change_runt rises=%0d want=2", rises);
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    hi = 0;
    for (int i = 0; i < PERIOD && (k % PERIOD) != 0; i++) tick();
    for (int i = 0; i < 200; i++) tick();
    rst     = 1'b1;
    bus.VIH = 8'h30;
    bus.VIL = 8'h90;
    tick();
    total++;
    if ({bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL midreset_outputs got=%b%b%b want=000",
               bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync);
    end
    rst = 1'b0;
    bus.VIH = 8'hEE;
    bus.VIL = 8'h11;
    tick();
    total++;
    if ({bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL midreset_resume got=%b%b%b want=111",
               bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync);
    end
    if (bus.VIH_PWM === 1'b1) hi++;
    for (int i = 1; i < PERIOD; i++) begin
      tick();
      total++;
      if ({bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync} !== {exp_h, exp_l, exp_s}) begin
        bad++;
        $display("[TB] FAIL midreset_model k=%0d got=%b%b%b want=%b%b%b", k,
                 bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync, exp_h, exp_l, exp_s);
      end
      if (bus.VIH_PWM === 1'b1) hi++;
    end
    total++;
    if (hi != 8'h30) begin
      bad++;
      $display("[TB] FAIL midreset_vih_count got=%0d want=48", hi);
    end
  endtask

  task automatic test_sync_period();
    int syncs, last;
    syncs = 0;
    last  = -1;
    for (int i = 0; i < PERIOD && (k % PERIOD) != 0; i++) tick();
    for (int i = 0; i < 10 * PERIOD; i++) begin
      tick();
      if (bus.pwm_sync === 1'b1) begin
        syncs++;
        if (last >= 0) begin
          total++;
          if (k - last != PERIOD) begin
            bad++;
            $display("[TB] FAIL sync_interval got=%0d want=256", k - last);
          end
        end
        last = k;
      end
    end
    total++;
    if (syncs != 10) begin
      bad++;
      $display("[TB] FAIL sync_count got=%0d want=10", syncs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * PERIOD; i++) begin
      if ($urandom_range(39) == 0) begin
        bus.VIH = 8'($urandom_range(255));
        bus.VIL = 8'($urandom_range(255));
      end
      tick();
      total++;
      if ({bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync} !== {exp_h, exp_l, exp_s}) begin
        bad++;
        $display("[TB] FAIL random_model k=%0d got=%b%b%b want=%b%b%b", k,
                 bus.VIH_PWM, bus.VIL_PWM, bus.pwm_sync, exp_h, exp_l, exp_s);
      end
    end
  endtask

`ifdef DUAL_PWM_PHASE_OFFSET_EN
  task automatic test_phase_offset();
    int   hi_h, hi_l, both, rise_h, rise_l;
    logic prev_h, prev_l;
    hi_h = 0; hi_l = 0; both = 0; rise_h = -1; rise_l = -1;
    bus.VIH = 8'h80;
    bus.VIL = 8'h80;
    for (int i = 0; i < 2 * PERIOD; i++) tick();
    for (int i = 0; i < PERIOD && (k % PERIOD) != 0; i++) tick();
    prev_h = bus.VIH_PWM;
    prev_l = bus.VIL_PWM;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (bus.VIH_PWM === 1'b1) hi_h++;
      if (bus.VIL_PWM === 1'b1) hi_l++;
      if (bus.VIH_PWM === 1'b1 && bus.VIL_PWM === 1'b1) both++;
      if (prev_h === 1'b0 && bus.VIH_PWM === 1'b1 && rise_h < 0) rise_h = i;
      if (prev_l === 1'b0 && bus.VIL_PWM === 1'b1 && rise_l < 0) rise_l = i;
      prev_h = bus.VIH_PWM;
      prev_l = bus.VIL_PWM;
    end
    total++;
    if (hi_h != 128 || hi_l != 128) begin
      bad++;
      $display("[TB] FAIL phase_counts vih=%0d vil=%0d want 128/128", hi_h, hi_l);
    end
    total++;
    if (both != 0) begin
      bad++;
      $display("[TB] FAIL phase_overlap got=%0d want=0", both);
    end
    total++;
    if (rise_h < 0 || rise_l - rise_h != 128) begin
      bad++;
      $display("[TB] FAIL phase_offset vih_rise=%0d vil_rise=%0d want diff 128", rise_h, rise_l);
    end
  endtask
`else
  task automatic test_equal_codes();
    logic [7:0] c;
    c = 8'($urandom_range(1, 254));
    bus.VIH = c;
    bus.VIL = c;
    for (int i = 0; i < 2 * PERIOD; i++) tick();
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      total++;
      if (bus.VIH_PWM !== exp_h || bus.VIL_PWM !== bus.VIH_PWM) begin
        bad++;
        $display("[TB] FAIL equal_codes k=%0d code=%0d vih=%b vil=%b want=%b", k, c,
                 bus.VIH_PWM, bus.VIL_PWM, exp_h);
      end
    end
  endtask
`endif

  initial begin
    total   = 0;
    bad     = 0;
    k       = 0;
    code_h  = 0;
    code_l  = 0;
    exp_h   = 1'b0;
    exp_l   = 1'b0;
    exp_s   = 1'b0;
    rst     = 1'b1;
    bus.VIH = '0;
    bus.VIL = '0;
    test_reset();
    test_duty_window();
    test_extremes();
    test_midperiod_change();
    test_reset_mid();
    test_sync_period();
    test_random();
`ifdef DUAL_PWM_PHASE_OFFSET_EN
    test_phase_offset();
`else
    test_equal_codes();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
